lap_timer_core: RTL

LAP_TIMER_CORE -- requirements
Module: lap_timer_core

---
 rtl/lap_timer_core.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lap_timer_core.sv
// rtl/lap_timer_core.sv - BCD stopwatch/countdown core with lap freeze and 8-digit multiplexed display
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   start       level input; each rising edge toggles run/stop
//   lap         level input; each rising edge toggles frozen/live display
//   clr         level input; rising edge zeroes (up) or presets (down) the time while stopped
//   mode        0 = count up, 1 = count down; taken only while stopped
//   preset      BCD hh:mm:ss:cc countdown load value, [31:28] = h_ten
//   seg_data    {a,b,c,d,e,f,g,dp}, active-high, registered
//   seg_com     active-low one-hot digit enable, bit 7 = leftmost, registered
//   running     high while counting
//   lap_active  high while the display shows the lap snapshot
//   done        one-cycle pulse when a countdown reaches zero
module lap_timer_core #(
  parameter int CLK_HZ   = 1000,
  parameter int SCAN_DIV = 1,
  parameter int HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        lap,
  input  logic        clr,
  input  logic        mode,
  input  logic [31:0] preset,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_com,
  output logic        running,
  output logic        lap_active,
  output logic        done
);

  localparam int PRE_DIV = CLK_HZ / 100;
  localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [7:0] HOUR_LAST = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  // Largest legal value of each digit, in the same nibble layout as the time.
  localparam logic [31:0] DIGIT_MAX = 32'h9959_5999;

  // Ripple a +1 through cc, ss, mm; hours wrap after HOUR_LAST.
  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        carry;
    r     = t;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (t[i*4 +: 4] >= DIGIT_MAX[i*4 +: 4]) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (carry) begin
      if (t[31:24] >= HOUR_LAST) begin
        r[31:24] = 8'h00;
      end else if (t[27:24] >= 4'd9) begin
        r[31:24] = {t[31:28] + 4'd1, 4'd0};
      end else begin
        r[27:24] = t[27:24] + 4'd1;
      end
    end
    return r;
  endfunction

  // Ripple a -1 with borrow; a zero digit reloads its maximum.
  function automatic logic [31:0] bcd_dec(input logic [31:0] t);
    logic [31:0] r;
    logic        borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (t[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = DIGIT_MAX[i*4 +: 4];
        end else begin
          r[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    // Hours never borrow below 00: an all-zero time stops the count first.
    if (borrow && (t[31:24] != 8'h00)) begin
      if (t[27:24] == 4'd0) begin
        r[31:24] = {t[31:28] - 4'd1, 4'd9};
      end else begin
        r[27:24] = t[27:24] - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] bcd_sat(input logic [31:0] t);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = (t[i*4 +: 4] > DIGIT_MAX[i*4 +: 4]) ? DIGIT_MAX[i*4 +: 4] : t[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic          start_q, lap_q, clr_q;
  // Low for the first cycle after reset so a level already high is not an edge.
  logic          armed;
  logic          start_ev, lap_ev, clr_ev;
  logic [31:0]   tm, snap;
  logic [31:0]   clr_val, tm_after_clr, tm_step, disp;
  logic [PW-1:0] pre;
  logic          mode_r;
  logic          tick, clr_ok, reach_zero, start_blocked;
  logic [SW-1:0] scan_div;
  logic [2:0]    slot;
  logic [3:0]    digit;
  logic          dp;

  always_comb begin
    start_ev      = armed & start & ~start_q;
    lap_ev        = armed & lap & ~lap_q;
    clr_ev        = armed & clr & ~clr_q;
    clr_ok        = clr_ev & ~running;
    clr_val       = mode ? bcd_sat(preset) : 32'h0;
    // A start in the same cycle as clr sees the freshly loaded time.
    tm_after_clr  = clr_ok ? clr_val : tm;
    start_blocked = mode & (tm_after_clr == 32'h0);
    tick          = running & (pre == PRE_LAST);
    tm_step       = mode_r ? bcd_dec(tm) : bcd_inc(tm);
    reach_zero    = tick & mode_r & (tm_step == 32'h0);
    disp          = lap_active ? snap : tm;
    // Slot 0 is the leftmost digit, i.e. the top nibble.
    digit         = disp[{~slot, 2'b00} +: 4];
    dp            = slot[0] & (slot != 3'd7);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q    <= 1'b0;
      lap_q      <= 1'b0;
      clr_q      <= 1'b0;
      armed      <= 1'b0;
      tm         <= 32'h0;
      snap       <= 32'h0;
      pre        <= '0;
      mode_r     <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      start_q <= start;
      lap_q   <= lap;
      clr_q   <= clr;
      armed   <= 1'b1;
      done    <= reach_zero;

      // Direction is frozen for the duration of a run.
      if (!running) mode_r <= mode;

      if (clr_ok)    tm <= clr_val;
      else if (tick) tm <= tm_step;

      if (clr_ok)       pre <= '0;
      else if (running) pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;

      if (reach_zero) begin
        running <= 1'b0;
      end else if (start_ev) begin
        if (running)             running <= 1'b0;
        else if (!start_blocked) running <= 1'b1;
      end

      if (clr_ok) begin
        lap_active <= 1'b0;
      end else if (lap_ev) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else begin
          snap       <= tm;
          lap_active <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_div <= '0;
      slot     <= 3'd0;
      seg_com  <= 8'hFF;
      seg_data <= 8'h00;
    end else begin
      if (scan_div == SCAN_LAST) begin
        scan_div <= '0;
        slot     <= slot + 3'd1;
      end else begin
        scan_div <= scan_div + 1'b1;
      end
      seg_com  <= ~(8'h80 >> slot);
      seg_data <= seg_code(digit) | {7'b0, dp};
    end
  end

endmodule
